// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the nibble-serial ALU path.
//   state_e    sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W   width of one adder slice pass
//   nibbles()  number of slice passes needed for a given operand width
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/adder_4bits.sv
// adder_4bits: 4-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   a_i, b_i  [3:0]  addends
//   cin_i            carry in
//   sum_o     [3:0]  sum
//   cout_o           carry out of bit 3
//   p_o, g_o         group propagate / generate for a higher lookahead level
module adder_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       p_o,
  output logic       g_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];
  assign p_o    = &p;
  assign g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add (optionally subtract) computed one
// nibble per cycle through a single shared adder_4bits slice, LSB nibble first.
// Build option: define NIBBLE_SUB_EN to honour the sub input (A-B); otherwise
// the sub input is ignored and the inversion logic is not built.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start_valid/start_ready        request handshake; a, b, sub sampled on accept
//   done_valid/done_ready          result handshake
//   result, carry_out, overflow, zero  registered result and flags
//
// state | meaning
// IDLE  | waiting for a request, start_ready high, outputs hold last result
// RUN   | one slice pass per cycle, idx counts nibbles 0..NIBBLES-1
// DONE  | done_valid high until done_ready
module nibble_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  logic             sub_accept;  // effective sub applied at accept (initial carry)
  logic             sub_run;     // effective sub during RUN (B inversion)
  logic [3:0]       b_eff;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;

`ifdef NIBBLE_SUB_EN
  logic sub_q, sub_d;
  assign sub_accept = sub;
  assign sub_run    = sub_q;
  assign b_eff      = b_sh_q[3:0] ^ {4{sub_run}};
`else
  assign sub_accept = 1'b0;
  assign sub_run    = 1'b0;
  assign b_eff      = b_sh_q[3:0];
`endif

  adder_4bits u_slice (
    .a_i    (a_sh_q[3:0]),
    .b_i    (b_eff),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .p_o    (),
    .g_o    ()
  );

  // Sums enter from the top so the LSB nibble lands at bit 0 after the last pass.
  assign acc_next = {slice_sum, acc_q[WIDTH-1:NIBBLE_W]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef NIBBLE_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          acc_d   = '0;
          carry_d = sub_accept;
          idx_d   = '0;
`ifdef NIBBLE_SUB_EN
          sub_d   = sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_next;
        carry_d = slice_cout;
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // a_sh_q[3] and b_eff[3] are the operand sign bits on this pass.
          res_d   = acc_next;
          cout_d  = slice_cout;
          ovf_d   = (a_sh_q[3] == b_eff[3]) && (slice_sum[3] != a_sh_q[3]);
          zero_d  = (acc_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef NIBBLE_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef NIBBLE_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign result      = res_q;
  assign carry_out   = cout_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed testbench for nibble_serial_adder_ctrl (WIDTH=32).
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        done_valid;
  logic        done_ready;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] held;

  nibble_serial_adder_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next negedge and wait (bounded) for done_valid.
  // lat counts negedges after the accept edge; done_valid first seen at lat=9.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a = av; b = bv; sub = sv; start_valid = 1'b1;
    chk("start_ready_before_accept", {31'b0, start_ready}, 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    lat = 1;
    while (!done_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk("start_ready_after_ack", {31'b0, start_ready}, 32'd1);
    chk("done_valid_after_ack", {31'b0, done_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; a = '0; b = '0; sub = 1'b0; done_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
    chk("rst_done_valid", {31'b0, done_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);

    // 0x0000FFFF + 1: carry ripples through four nibbles
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    chk("lat_ffff", lat, 32'd9);
    chk("res_ffff", result, 32'h0001_0000);
    chk("cout_ffff", {31'b0, carry_out}, 32'd0);
    chk("zero_ffff", {31'b0, zero}, 32'd0);
    chk("ovf_ffff", {31'b0, overflow}, 32'd0);
    ack();
    chk("hold_idle_res", result, 32'h0001_0000);

    // all-ones + 1: wraps to zero with carry out
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("lat_wrap", lat, 32'd9);
    chk("res_wrap", result, 32'h0);
    chk("cout_wrap", {31'b0, carry_out}, 32'd1);
    chk("zero_wrap", {31'b0, zero}, 32'd1);
    chk("ovf_wrap", {31'b0, overflow}, 32'd0);
    ack();

    // positive overflow
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("res_povf", result, 32'h8000_0000);
    chk("ovf_povf", {31'b0, overflow}, 32'd1);
    chk("cout_povf", {31'b0, carry_out}, 32'd0);
    chk("zero_povf", {31'b0, zero}, 32'd0);
    ack();

    // negative overflow
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("res_novf", result, 32'h7FFF_FFFF);
    chk("ovf_novf", {31'b0, overflow}, 32'd1);
    chk("cout_novf", {31'b0, carry_out}, 32'd1);
    ack();

    // 5 - 7 when subtract is built in, 5 + 7 otherwise
    issue(32'd5, 32'd7, 1'b1);
`ifdef NIBBLE_SUB_EN
    chk("res_sub", result, 32'hFFFF_FFFE);
`else
    chk("res_sub", result, 32'd12);
`endif
    chk("cout_sub", {31'b0, carry_out}, 32'd0);
    chk("ovf_sub", {31'b0, overflow}, 32'd0);
    ack();

    // abort: reset during RUN, no done_valid may follow
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_res", result, 32'h0);
    chk("abort_ready", {31'b0, start_ready}, 32'd1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_valid) lat++;
    end
    chk("abort_no_done", lat, 32'd0);

    // new request after abort, then back-pressure for 5 cycles
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    chk("lat_bp", lat, 32'd9);
    chk("res_bp", result, 32'h2345_6789);
    chk("cout_bp", {31'b0, carry_out}, 32'd0);
    held = result;
    start_valid = 1'b1;
    a = 32'hDEAD_BEEF; b = 32'h1;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!done_valid || start_ready || result !== held) lat++;
    end
    chk("bp_stable", lat, 32'd0);
    start_valid = 1'b0;
    ack();
    chk("bp_hold_idle", result, 32'h2345_6789);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that computes a WIDTH-bit add, or subtract when enabled, by driving one shared 4-bit carry-lookahead slice once per nibble, least-significant nibble first. It trades latency for area in the processor's low-cost ALU path. It presents a valid/ready request port to the issuing logic and a valid/ready result port back to it. Carry is held in a register between nibble cycles.

## Interface
- WIDTH, 32: operand width; must be a multiple of 4 and at least 8.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start_valid  in  1  request present.
- start_ready  out  1  controller can accept; high only in IDLE.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- sub  in  1  1 = A−B; sampled on accept; ignored unless NIBBLE_SUB_EN.
- result  out  WIDTH  sum/difference; stable while done_valid.
- carry_out  out  1  carry from the MSB nibble (borrow-not for subtract).
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- done_valid  out  1  result outputs valid.
- done_ready  in  1  consumer accepts the result.

## Operation
- NIBBLES = WIDTH/4. Counter width is clog2(NIBBLES).
- States:
  - IDLE: start_ready=1. On start_valid, load the A/B shift registers, clear the result register, set carry_reg = sub_eff, set idx=0, go to RUN.
  - RUN: the slice gets a_sh[3:0], b_eff[3:0] and carry_reg each cycle.
    - Shift its sum into result from the top: result <= {sum, result[WIDTH-1:4]}.
    - carry_reg <= cout. Shift a_sh and b_sh right by 4. idx++.
    - When idx==NIBBLES-1, go to DONE.
  - DONE: done_valid=1. On done_ready, go to IDLE.
- sub_eff = sub when NIBBLE_SUB_EN is defined, else 0. b_eff = b_sh[3:0] XOR {4{sub_eff}}.
- Flags are captured on the final RUN cycle:
  - carry_out = slice cout.
  - overflow = (a_msb == b_eff_msb) && (sum[3] != a_msb), where a_msb and b_eff_msb are the operand sign bits entering the last nibble.
  - zero = ({sum, result[WIDTH-1:4]} == 0).
- Reset values: state=IDLE, result=0, carry_out=0, overflow=0, zero=0, done_valid=0. start_ready=1 from the first cycle after reset.
- Reset in RUN or DONE aborts the operation. No partial result or done_valid is emitted.
- start_valid while not IDLE is ignored. The requester must hold its request.
- Outputs are unchanged in IDLE; they hold the last result until the next DONE overwrites them.

## Timing
- Accept edge T, in IDLE with start_valid=1.
- Nibble k is computed in cycle T+1+k, k = 0..NIBBLES-1.
- done_valid rises in cycle T+1+NIBBLES. Latency is 9 cycles for WIDTH=32.
- Handshake completes at the first edge with done_valid && done_ready. start_ready is high the following cycle.
- Minimum initiation interval is NIBBLES+2 cycles.
- The slice path is purely combinational within one cycle. No combinational path exists from start_valid or done_ready to any output.

## Configuration
- NIBBLE_SUB_EN defined:
  - sub is honoured: B is inverted per nibble and the initial carry is 1.
  - carry_out=1 means no borrow.
- NIBBLE_SUB_EN undefined:
  - sub port is present but unused. Operation is always A+B with initial carry 0.
  - Inversion XOR logic is removed.

## Structure
- Shared package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam NIBBLE_W = 4;
  - a function computing NIBBLES from WIDTH.
- Sub-module: one instance of adder_4bits, the team's existing 4-bit CLA slice. Its P and G outputs are left unconnected.
- Sequencing, shift registers and flag logic stay in nibble_serial_adder_ctrl.

## Test plan
- Reset, then idle: start_ready=1, done_valid=0, result=0, all flags 0.
- a=0x0000_FFFF, b=0x0000_0001, add → done_valid at T+9, result=0x0001_0000, carry_out=0, zero=0.
- a=0xFFFF_FFFF, b=0x0000_0001 → result=0, carry_out=1, zero=1, overflow=0.
- a=0x7FFF_FFFF, b=0x0000_0001 → result=0x8000_0000, overflow=1.
- With NIBBLE_SUB_EN, a=5, b=7, sub=1 → result=0xFFFF_FFFE, carry_out=0. Without the macro, same stimulus → result=12.
- Reset asserted at T+4, then a new request: no done_valid from the aborted operation; the new result is correct. Hold done_ready=0 for 5 cycles: outputs stay stable and start_ready=0.
